mem_port_arbiter: RTL and testbench

Two-requester arbiter for the single-ported unified instruction/data memory of the multi-cycle MIPS core. It shares the memory between the CPU control path (fetch, lw, sw) and the program loader/debug port. Arbitration is round-robin, with an optional loader lock for burst loads and a bounded lock length so the CPU is never starved. It sits between both requesters and the memory macro. It drives cpu_stall, which the CPU FSM uses to hold pcen/IRWrite while its access is not granted.

---
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared-memory port bundle between the CPU control path, the program
// loader/debug port, the memory macro and the arbiter that joins them.
// The arbiter takes the slave view; requesters and memory take the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 10
);
    // CPU requester
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [31:0]   c_wdata;
    logic          c_gnt;
    logic          c_rvalid;

    // Loader / debug requester
    logic          l_req;
    logic          l_we;
    logic          l_lock;
    logic [AW-1:0] l_addr;
    logic [31:0]   l_wdata;
    logic          l_gnt;
    logic          l_rvalid;

    // Shared read data, qualified by c_rvalid / l_rvalid
    logic [31:0]   rdata;

    // Memory macro side (synchronous read, 1-cycle latency)
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;

    // Hold request for the CPU FSM
    logic          cpu_stall;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  l_req, l_we, l_lock, l_addr, l_wdata,
        input  m_rdata,
        output c_gnt, c_rvalid, l_gnt, l_rvalid, rdata,
        output m_en, m_we, m_addr, m_wdata,
        output cpu_stall
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output l_req, l_we, l_lock, l_addr, l_wdata,
        output m_rdata,
        input  c_gnt, c_rvalid, l_gnt, l_rvalid, rdata,
        input  m_en, m_we, m_addr, m_wdata,
        input  cpu_stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the single-ported unified instruction/data memory.
// The loader may lock the port for burst loads; after MAX_LOCK consecutive
// locked grants the CPU gets a forced slot so it is never starved.
// MAX_LOCK must be at least 2.
module mem_port_arbiter #(
    parameter int AW       = 10,
    parameter int MAX_LOCK = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_LOCK) + 1;
    localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

    localparam logic [1:0] ST_ARB   = 2'd0;  // normal round-robin
    localparam logic [1:0] ST_LOCK  = 2'd1;  // loader owns the port
    localparam logic [1:0] ST_YIELD = 2'd2;  // forced CPU slot

    localparam logic LW_CPU = 1'b0;
    localparam logic LW_LDR = 1'b1;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] lock_cnt, lock_cnt_nxt;
    logic          last_winner;
    logic          c_rvalid_q, l_rvalid_q;

    logic          rr_c, rr_l;
    logic          c_win, l_win;
    logic [AW-1:0] addr_mux;

    // Round-robin decision: sole requester wins, a tie goes to the side that did not win last
    always_comb begin
        rr_c = bus.c_req & (~bus.l_req | (last_winner == LW_LDR));
        rr_l = bus.l_req & (~bus.c_req | (last_winner == LW_CPU));
    end

    // Grant selection per state; grants are suppressed while reset is asserted
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred
        c_win = 1'b0;
        l_win = 1'b0;
        case (state)
            ST_LOCK: begin
                if (bus.l_req & bus.l_lock) begin
                    l_win = 1'b1;
                end else begin
                    c_win = rr_c;
                    l_win = rr_l;
                end
            end
            ST_YIELD: begin
                if (bus.c_req) c_win = 1'b1;
                else           l_win = bus.l_req;
            end
            default: begin
                c_win = rr_c;
                l_win = rr_l;
            end
        endcase
        if (!rst_n) begin
            c_win = 1'b0;
            l_win = 1'b0;
        end
    end

    // Next state and lock-length counter
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        case (state)
            ST_LOCK: begin
                if (bus.l_req & bus.l_lock) begin
                    lock_cnt_nxt = lock_cnt + CW'(1);
                    if (lock_cnt == LOCK_LAST) state_nxt = ST_YIELD;
                end else begin
                    state_nxt    = ST_ARB;
                    lock_cnt_nxt = '0;
                end
            end
            ST_YIELD: begin
                if (l_win & bus.l_lock) begin
                    state_nxt    = ST_LOCK;
                    lock_cnt_nxt = CW'(1);
                end else begin
                    state_nxt    = ST_ARB;
                    lock_cnt_nxt = '0;
                end
            end
            ST_ARB: begin
                if (l_win & bus.l_lock) begin
                    state_nxt    = ST_LOCK;
                    lock_cnt_nxt = CW'(1);
                end
            end
            default: begin
                state_nxt    = ST_ARB;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // Arbitration state, winner history and read-valid pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ARB;
            lock_cnt    <= '0;
            last_winner <= LW_LDR;
            c_rvalid_q  <= 1'b0;
            l_rvalid_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values
            state      <= state_nxt;
            lock_cnt   <= lock_cnt_nxt;
            c_rvalid_q <= c_win & ~bus.c_we;
            l_rvalid_q <= l_win & ~bus.l_we;
            if (c_win)      last_winner <= LW_CPU;
            else if (l_win) last_winner <= LW_LDR;
        end
    end

    // Memory-side mux driven by whichever requester holds the grant
    always_comb begin
        addr_mux = c_win ? bus.c_addr : bus.l_addr;
    end

    assign bus.c_gnt     = c_win;
    assign bus.l_gnt     = l_win;
    assign bus.c_rvalid  = c_rvalid_q;
    assign bus.l_rvalid  = l_rvalid_q;
    assign bus.rdata     = bus.m_rdata;
    assign bus.m_en      = c_win | l_win;
    assign bus.m_we      = (c_win & bus.c_we) | (l_win & bus.l_we);
    assign bus.m_addr    = addr_mux;
    assign bus.m_wdata   = c_win ? bus.c_wdata : bus.l_wdata;
    assign bus.cpu_stall = rst_n & bus.c_req & ~c_win;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency memory.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;
    localparam int AW = 10;

    localparam logic [1:0] S_ARB   = 2'd0;
    localparam logic [1:0] S_LOCK  = 2'd1;
    localparam logic [1:0] S_YIELD = 2'd2;

    localparam logic [31:0] D_CPU = 32'h2008_0005;  // word at 0x004
    localparam logic [31:0] D_LDR = 32'hDEAD_BEEF;  // word at 0x100

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_port_arbiter_if #(.AW(AW)) bus ();

    mem_port_arbiter #(.AW(AW), .MAX_LOCK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: preloads two words on the first edge, then serves the bus
    logic [31:0] mem [0:(1<<AW)-1];
    logic        preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            mem[10'h004] <= D_CPU;
            mem[10'h100] <= D_LDR;
            preloaded    <= 1'b1;
        end else if (bus.m_en) begin
            if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
            else          bus.m_rdata     <= mem[bus.m_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_c, exp_l;
        int   ld_idx;

        // ---- Reset with both requesters active ----
        rst_n       = 1'b0;
        bus.c_req   = 1'b1; bus.c_we = 1'b0; bus.c_addr = 10'h004; bus.c_wdata = '0;
        bus.l_req   = 1'b1; bus.l_we = 1'b0; bus.l_lock = 1'b0;
        bus.l_addr  = 10'h100; bus.l_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_c_gnt",     32'(bus.c_gnt),     32'd0);
        check("rst_l_gnt",     32'(bus.l_gnt),     32'd0);
        check("rst_m_en",      32'(bus.m_en),      32'd0);
        check("rst_m_we",      32'(bus.m_we),      32'd0);
        check("rst_c_rvalid",  32'(bus.c_rvalid),  32'd0);
        check("rst_l_rvalid",  32'(bus.l_rvalid),  32'd0);
        check("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // ---- Contention without lock: C,L,C,L,C,L ----
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_c = (k % 2 == 0);
            check("cont_c_gnt",  32'(bus.c_gnt),  32'(exp_c));
            check("cont_l_gnt",  32'(bus.l_gnt),  32'(!exp_c));
            check("cont_m_addr", 32'(bus.m_addr), exp_c ? 32'h004 : 32'h100);
            if (k > 0) begin
                check("cont_c_rvalid", 32'(bus.c_rvalid), 32'(!exp_c));
                check("cont_l_rvalid", 32'(bus.l_rvalid), 32'(exp_c));
                check("cont_rdata",    bus.rdata,         exp_c ? D_LDR : D_CPU);
            end
            next_cycle();
        end

        // ---- CPU-only read of 0x004 ----
        bus.l_req = 1'b0;
        @(negedge clk);
        check("rd_c_gnt",     32'(bus.c_gnt),     32'd1);
        check("rd_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        next_cycle();
        bus.c_req = 1'b0;
        @(negedge clk);
        check("rd_c_rvalid", 32'(bus.c_rvalid), 32'd1);
        check("rd_rdata",    bus.rdata,         D_CPU);
        check("rd_l_rvalid", 32'(bus.l_rvalid), 32'd0);
        next_cycle();

        // ---- Lock bound: 12 locked loader writes vs continuous CPU reads ----
        ld_idx      = 0;
        bus.c_req   = 1'b1; bus.c_we = 1'b0; bus.c_addr = 10'h004;
        bus.l_req   = 1'b1; bus.l_we = 1'b1; bus.l_lock = 1'b1;
        bus.l_addr  = 10'h200; bus.l_wdata = 32'h1000;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            exp_l = (k % 5) != 4;
            check("lock_l_gnt",     32'(bus.l_gnt),     32'(exp_l));
            check("lock_c_gnt",     32'(bus.c_gnt),     32'(!exp_l));
            check("lock_cpu_stall", 32'(bus.cpu_stall), 32'(exp_l));
            if (exp_l) begin
                check("lock_m_we",    32'(bus.m_we),   32'd1);
                check("lock_m_addr",  32'(bus.m_addr), 32'h200 + 32'(ld_idx));
                check("lock_m_wdata", bus.m_wdata,     32'h1000 + 32'(ld_idx));
            end
            if (k == 5 || k == 10) begin
                check("lock_c_rvalid", 32'(bus.c_rvalid), 32'd1);
                check("lock_rdata",    bus.rdata,         D_CPU);
            end
            if (bus.l_gnt) ld_idx++;
            next_cycle();
            if (ld_idx >= 12) begin
                bus.l_req = 1'b0;
            end else begin
                bus.l_addr  = AW'(10'h200 + ld_idx);
                bus.l_wdata = 32'h1000 + 32'(ld_idx);
            end
        end
        bus.c_req = 1'b0;
        check("lock_mem_first", mem[10'h200], 32'h1000);
        check("lock_mem_last",  mem[10'h20B], 32'h100B);

        // ---- Lock saturates with idle CPU: loader keeps every slot ----
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_lock = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.l_addr  = AW'(10'h300 + k);
            bus.l_wdata = 32'h3000 + 32'(k);
            @(negedge clk);
            check("yld_l_gnt", 32'(bus.l_gnt), 32'd1);
            if (k == 0) check("yld_state_arb", 32'(dut.state), 32'(S_ARB));
            if (k == 4) begin
                check("yld_state_yield", 32'(dut.state),    32'(S_YIELD));
                check("yld_cnt_sat",     32'(dut.lock_cnt), 32'd4);
            end
            if (k == 5) begin
                check("yld_state_relock", 32'(dut.state),    32'(S_LOCK));
                check("yld_cnt_relock",   32'(dut.lock_cnt), 32'd1);
            end
            next_cycle();
        end

        // ---- Lock release coinciding with CPU request ----
        bus.l_lock = 1'b0; bus.l_we = 1'b0; bus.l_addr = 10'h100;
        bus.c_req  = 1'b1; bus.c_we = 1'b0; bus.c_addr = 10'h004;
        @(negedge clk);
        check("rel_c_gnt", 32'(bus.c_gnt), 32'd1);
        check("rel_l_gnt", 32'(bus.l_gnt), 32'd0);
        next_cycle();
        bus.c_req = 1'b0; bus.l_req = 1'b0;
        @(negedge clk);
        check("rel_state",    32'(dut.state),    32'(S_ARB));
        check("rel_cnt",      32'(dut.lock_cnt), 32'd0);
        check("rel_c_rvalid", 32'(bus.c_rvalid), 32'd1);
        next_cycle();

        // ---- Reset pulsed during a granted CPU read ----
        bus.c_req = 1'b1;
        @(negedge clk);
        check("mrst_c_gnt", 32'(bus.c_gnt), 32'd1);
        #1;
        rst_n = 1'b0; bus.c_req = 1'b0;
        #1;
        check("mrst_c_rvalid_in", 32'(bus.c_rvalid), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_c_rvalid_out", 32'(bus.c_rvalid), 32'd0);
        check("mrst_state",        32'(dut.state),    32'(S_ARB));
        check("mrst_cnt",          32'(dut.lock_cnt), 32'd0);
        next_cycle();

        // ---- Reset during a locked burst: pending write dropped, FSM restarts ----
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_lock = 1'b1;
        bus.l_addr = 10'h3F0; bus.l_wdata = 32'hA1;
        @(negedge clk);
        check("lrst_l_gnt_a", 32'(bus.l_gnt), 32'd1);
        next_cycle();
        bus.l_addr = 10'h3F1; bus.l_wdata = 32'hA2;
        @(negedge clk);
        check("lrst_l_gnt_b", 32'(bus.l_gnt),  32'd1);
        check("lrst_state",   32'(dut.state),  32'(S_LOCK));
        #1;
        rst_n = 1'b0; bus.l_req = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("lrst_state_after", 32'(dut.state),    32'(S_ARB));
        check("lrst_cnt_after",   32'(dut.lock_cnt), 32'd0);
        check("lrst_mem_done",    mem[10'h3F0],      32'hA1);
        check("lrst_mem_dropped", 32'(mem[10'h3F1] === 32'hA2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
